// File: rtl/ysyx_24110006_bus_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
// State encoding, master indices and default bus widths.
package ysyx_24110006_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/ysyx_24110006_mem_arbiter_if.sv
// Two-master / one-slave memory bus bundle.
// slave: arbiter view; master: view of the IFU, LSU and memory around it.
interface ysyx_24110006_mem_arbiter_if
  import ysyx_24110006_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);

  logic [1:0]              i_m_req_valid;
  logic [1:0]              o_m_req_ready;
  logic [1:0]              i_m_req_wen;
  logic [2*ADDR_W-1:0]     i_m_req_addr;
  logic [2*DATA_W-1:0]     i_m_req_wdata;
  logic [2*DATA_W/8-1:0]   i_m_req_wmask;

  logic [1:0]              o_m_rsp_valid;
  logic [1:0]              i_m_rsp_ready;
  logic [DATA_W-1:0]       o_m_rsp_rdata;
  logic                    o_m_rsp_err;

  logic                    o_s_req_valid;
  logic                    i_s_req_ready;
  logic                    o_s_req_wen;
  logic [ADDR_W-1:0]       o_s_req_addr;
  logic [DATA_W-1:0]       o_s_req_wdata;
  logic [DATA_W/8-1:0]     o_s_req_wmask;

  logic                    i_s_rsp_valid;
  logic                    o_s_rsp_ready;
  logic [DATA_W-1:0]       i_s_rsp_rdata;
  logic                    i_s_rsp_err;

  modport slave (
    input  i_m_req_valid, i_m_req_wen,
    input  i_m_req_addr, i_m_req_wdata,
    input  i_m_req_wmask, i_m_rsp_ready,
    input  i_s_req_ready, i_s_rsp_valid,
    input  i_s_rsp_rdata, i_s_rsp_err,
    output o_m_req_ready, o_m_rsp_valid,
    output o_m_rsp_rdata, o_m_rsp_err,
    output o_s_req_valid, o_s_req_wen,
    output o_s_req_addr, o_s_req_wdata,
    output o_s_req_wmask, o_s_rsp_ready
  );

  modport master (
    output i_m_req_valid, i_m_req_wen,
    output i_m_req_addr, i_m_req_wdata,
    output i_m_req_wmask, i_m_rsp_ready,
    output i_s_req_ready, i_s_rsp_valid,
    output i_s_rsp_rdata, i_s_rsp_err,
    input  o_m_req_ready, o_m_rsp_valid,
    input  o_m_rsp_rdata, o_m_rsp_err,
    input  o_s_req_valid, o_s_req_wen,
    input  o_s_req_addr, o_s_req_wdata,
    input  o_s_req_wmask, o_s_rsp_ready
  );

endinterface

// File: rtl/ysyx_24110006_rr_arb.sv
// Two-input round-robin pick; on a tie the master
// that did not win last time gets the one-hot grant.
module ysyx_24110006_rr_arb
  import ysyx_24110006_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = (last == LSU) ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_mem_arbiter.sv
// IFU/LSU to single memory slave arbiter.
// One outstanding transaction; request registered, response passed through.
module ysyx_24110006_mem_arbiter
  import ysyx_24110006_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
)(
  input logic                        i_clock,
  input logic                        i_reset,
  ysyx_24110006_mem_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;

  state_t state_q;
  state_t state_d;

  logic              grant_q;
  logic              last_q;
  logic [1:0]        gnt;
  logic              sel;
  logic              m_hs;

  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic              wen_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [MASK_W-1:0] wmask_sel;

  ysyx_24110006_rr_arb u_rr_arb (
    .req  (bus.i_m_req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign sel  = gnt[1];
  assign m_hs = (state_q == IDLE) && (|gnt);

  assign wen_sel   = bus.i_m_req_wen[sel];
  assign addr_sel  = sel ? bus.i_m_req_addr[2*ADDR_W-1:ADDR_W]
                         : bus.i_m_req_addr[ADDR_W-1:0];
  assign wdata_sel = sel ? bus.i_m_req_wdata[2*DATA_W-1:DATA_W]
                         : bus.i_m_req_wdata[DATA_W-1:0];
  assign wmask_sel = sel ? bus.i_m_req_wmask[2*MASK_W-1:MASK_W]
                         : bus.i_m_req_wmask[MASK_W-1:0];

  assign bus.o_s_req_wen   = wen_q;
  assign bus.o_s_req_addr  = addr_q;
  assign bus.o_s_req_wdata = wdata_q;
  assign bus.o_s_req_wmask = wmask_q;

  always_comb begin
    state_d           = state_q;
    bus.o_m_req_ready = 2'b00;
    bus.o_m_rsp_valid = 2'b00;
    bus.o_m_rsp_rdata = '0;
    bus.o_m_rsp_err   = 1'b0;
    bus.o_s_req_valid = 1'b0;
    bus.o_s_rsp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.o_m_req_ready = gnt;
        if (|gnt) state_d = REQ;
      end
      REQ: begin
        bus.o_s_req_valid = 1'b1;
        if (bus.i_s_req_ready) state_d = RSP;
      end
      RSP: begin
        bus.o_s_rsp_ready = bus.i_m_rsp_ready[grant_q];
        bus.o_m_rsp_valid[grant_q] = bus.i_s_rsp_valid;
        bus.o_m_rsp_rdata = bus.i_s_rsp_rdata;
        bus.o_m_rsp_err   = bus.i_s_rsp_err;
        if (bus.i_s_rsp_valid && bus.i_m_rsp_ready[grant_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to LSU so the IFU wins the first tie
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      grant_q <= IFU;
      last_q  <= LSU;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (m_hs) begin
        grant_q <= sel;
        last_q  <= sel;
        wen_q   <= wen_sel;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
        wmask_q <= wmask_sel;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter.
// Directed stimulus pushes expected responses; a monitor pops on handshake.
module tb_ysyx_24110006_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int          m;
    logic        wen;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  ysyx_24110006_mem_arbiter_if bus ();

  ysyx_24110006_mem_arbiter dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic wen,
                      input logic [31:0] rdata, input logic err);
    exp_t e;
    e.m = m; e.wen = wen; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int m, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
    bus.i_m_req_wen[m]            = wen;
    bus.i_m_req_addr[m*32 +: 32]  = addr;
    bus.i_m_req_wdata[m*32 +: 32] = wdata;
    bus.i_m_req_wmask[m*4 +: 4]   = wmask;
    bus.i_m_req_valid[m]          = 1'b1;
  endtask

  task automatic wait_grant(input int m, output int gcyc);
    bit ok;
    ok = 0;
    gcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_m_req_ready[m]) begin
        gcyc = cyc;
        ok = 1;
        @(posedge clk);
        #1;
        bus.i_m_req_valid[m] = 1'b0;
        break;
      end
    end
    if (!ok) fail($sformatf("grant_m%0d", m));
  endtask

  task automatic master_seq(input int m, input int n,
                            input logic [31:0] base, output int first_g);
    int g;
    first_g = -1;
    for (int i = 0; i < n; i++) begin
      issue(m, 1'b0, base + 32'(4 * i), 32'h0, 4'h0);
      wait_grant(m, g);
      if (i == 0) first_g = g;
    end
  endtask

  task automatic slave_serve(input int stall, input logic wen,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wmask, input logic [31:0] rdata,
                             input logic err, output int req_cyc,
                             output int rsp_cyc);
    bit ok;
    ok = 0;
    req_cyc = -1;
    rsp_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_s_req_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail("s_req_valid");
      return;
    end
    req_cyc = cyc;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      check("s_req_valid", bus.o_s_req_valid, 1);
      check("s_req_wen", bus.o_s_req_wen, wen);
      check("s_req_addr", bus.o_s_req_addr, addr);
      check("s_req_wdata", bus.o_s_req_wdata, wdata);
      check("s_req_wmask", bus.o_s_req_wmask, wmask);
      check("m_req_ready_busy", bus.o_m_req_ready, 2'b00);
    end
    bus.i_s_req_ready = 1'b1;
    tick();
    bus.i_s_req_ready = 1'b0;
    bus.i_s_rsp_valid = 1'b1;
    bus.i_s_rsp_rdata = rdata;
    bus.i_s_rsp_err   = err;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_s_rsp_ready) begin
        ok = 1;
        rsp_cyc = cyc;
        break;
      end
    end
    if (!ok) fail("s_rsp_ready");
    tick();
    bus.i_s_rsp_valid = 1'b0;
    bus.i_s_rsp_rdata = 32'h0;
    bus.i_s_rsp_err   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (bus.o_m_rsp_valid[m] && bus.i_m_rsp_ready[m]) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            mon_e = exp_q.pop_front();
            check("rsp_master", m, mon_e.m);
            if (!mon_e.wen) check("rsp_rdata", bus.o_m_rsp_rdata, mon_e.rdata);
            check("rsp_err", bus.o_m_rsp_err, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g0, g1, rq, rs, ifu_g, lsu_g, ifu_rs;
    bit seen;

    bus.i_m_req_valid = 2'b00;
    bus.i_m_req_wen   = 2'b00;
    bus.i_m_req_addr  = '0;
    bus.i_m_req_wdata = '0;
    bus.i_m_req_wmask = '0;
    bus.i_m_rsp_ready = 2'b11;
    bus.i_s_req_ready = 1'b0;
    bus.i_s_rsp_valid = 1'b0;
    bus.i_s_rsp_rdata = 32'h0;
    bus.i_s_rsp_err   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_handshakes", {bus.o_m_req_ready, bus.o_m_rsp_valid,
          bus.o_s_req_valid, bus.o_s_rsp_ready}, 0);
    check("rst_req_fields", {bus.o_s_req_wen, bus.o_s_req_wmask,
          bus.o_s_req_addr}, 0);
    check("rst_wdata", bus.o_s_req_wdata, 0);
    check("rst_rsp_data", {bus.o_m_rsp_err, bus.o_m_rsp_rdata}, 0);
    rst_n = 1'b1;

    // both masters keep requesting: grants must alternate
    tick();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 32'h1000 + i, 1'b0);
      push(1, 1'b0, 32'h2000 + i, 1'b0);
    end
    ifu_rs = -1;
    fork
      master_seq(0, 3, 32'h100, ifu_g);
      master_seq(1, 3, 32'h200, lsu_g);
      for (int i = 0; i < 6; i++) begin
        slave_serve(0, 1'b0,
                    (i % 2 == 1) ? 32'h200 + 32'(4 * (i / 2))
                                 : 32'h100 + 32'(4 * (i / 2)),
                    32'h0, 4'h0,
                    (i % 2 == 1) ? 32'h2000 + 32'(i / 2)
                                 : 32'h1000 + 32'(i / 2),
                    1'b0, rq, rs);
        if (i == 0) ifu_rs = rs;
      end
    join
    check("tie_lsu_after_ifu_rsp", lsu_g, ifu_rs + 1);

    tick();
    issue(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    push(0, 1'b0, 32'h0010_0073, 1'b0);
    fork
      wait_grant(0, g);
      slave_serve(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0,
                  32'h0010_0073, 1'b0, rq, rs);
    join
    check("rd_req_latency", rq, g + 1);
    check("rd_rsp_latency", rs, g + 2);

    // LSU write stalled by slave; IFU arrives during the stall
    tick();
    issue(1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
    push(1, 1'b1, 32'h0, 1'b0);
    push(0, 1'b0, 32'h0000_0013, 1'b0);
    fork
      wait_grant(1, g);
      begin
        tick();
        issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        wait_grant(0, g1);
      end
      begin
        slave_serve(3, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011,
                    32'h0, 1'b0, rq, rs);
        slave_serve(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0,
                    32'h0000_0013, 1'b0, g0, ifu_rs);
      end
    join
    check("wr_stall_rsp_cycle", rs, rq + 4);
    check("ifu_after_lsu_rsp", g1, rs + 1);

    // error response while the LSU holds off for 2 cycles
    tick();
    bus.i_m_rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 32'h8000_2000, 32'h0, 4'h0);
    push(1, 1'b0, 32'hBAD0_BAD0, 1'b1);
    fork
      wait_grant(1, g);
      slave_serve(0, 1'b0, 32'h8000_2000, 32'h0, 4'h0,
                  32'hBAD0_BAD0, 1'b1, rq, rs);
      begin
        seen = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.o_m_rsp_valid[1]) begin
            seen = 1;
            break;
          end
        end
        if (!seen) begin
          fail("bp_rsp_valid");
        end else begin
          check("bp_s_rsp_ready_c0", bus.o_s_rsp_ready, 0);
          check("bp_m_rsp_valid", bus.o_m_rsp_valid, 2'b10);
          @(negedge clk);
          check("bp_s_rsp_ready_c1", bus.o_s_rsp_ready, 0);
          tick();
          bus.i_m_rsp_ready[1] = 1'b1;
        end
      end
    join
    bus.i_m_rsp_ready = 2'b11;
    check("bp_rsp_cycle", rs, rq + 3);
    @(negedge clk);
    check("bp_idle_after", {bus.o_s_req_valid, bus.o_m_rsp_valid,
          bus.o_s_rsp_ready}, 0);

    tick();
    bus.i_s_rsp_valid = 1'b1;
    bus.i_s_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("unsol_s_rsp_ready", bus.o_s_rsp_ready, 0);
    check("unsol_m_rsp_valid", bus.o_m_rsp_valid, 2'b00);
    check("unsol_rdata", bus.o_m_rsp_rdata, 0);
    tick();
    bus.i_s_rsp_valid = 1'b0;
    bus.i_s_rsp_rdata = 32'h0;

    // asynchronous reset while parked in RSP
    issue(0, 1'b0, 32'h8000_3000, 32'h0, 4'h0);
    bus.i_m_rsp_ready = 2'b00;
    wait_grant(0, g);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_s_req_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("rst_s_req_valid");
    bus.i_s_req_ready = 1'b1;
    tick();
    bus.i_s_req_ready = 1'b0;
    bus.i_s_rsp_valid = 1'b1;
    bus.i_s_rsp_rdata = 32'h55;
    @(negedge clk);
    check("rst_pre_rsp_valid", bus.o_m_rsp_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_handshakes", {bus.o_m_req_ready, bus.o_m_rsp_valid,
          bus.o_s_req_valid, bus.o_s_rsp_ready}, 0);
    check("rst_mid_req_fields", {bus.o_s_req_wen, bus.o_s_req_wmask,
          bus.o_s_req_addr}, 0);
    check("rst_mid_rsp_data", {bus.o_m_rsp_err, bus.o_m_rsp_rdata}, 0);
    bus.i_s_rsp_valid = 1'b0;
    bus.i_s_rsp_rdata = 32'h0;
    bus.i_m_rsp_ready = 2'b11;
    @(posedge clk);
    #3 rst_n = 1'b1;

    tick();
    issue(0, 1'b0, 32'h8000_4000, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h8000_5000, 32'h0, 4'h0);
    push(0, 1'b0, 32'h0000_4444, 1'b0);
    push(1, 1'b0, 32'h0000_5555, 1'b0);
    fork
      wait_grant(0, g0);
      wait_grant(1, g1);
      begin
        slave_serve(0, 1'b0, 32'h8000_4000, 32'h0, 4'h0,
                    32'h0000_4444, 1'b0, rq, rs);
        slave_serve(0, 1'b0, 32'h8000_5000, 32'h0, 4'h0,
                    32'h0000_5555, 1'b0, rq, rs);
      end
    join
    check("post_rst_ifu_first", g0 < g1, 1);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_mem_arbiter.md
# ysyx_24110006_mem_arbiter

Two-master, one-slave memory-bus arbiter between the core's instruction fetch unit (master 0) and load/store unit (master 1) and the single memory slave. It grants one master at a time, registers the granted request and forwards it to the slave. It routes the slave's single response back to the granted master. This lets the IFU and LSU share one memory port without either seeing the other's traffic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- i_clock  in  1  core clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_m_req_valid  in  2  request valid; bit0 = IFU, bit1 = LSU
- o_m_req_ready  out  2  request accepted, per master
- i_m_req_wen  in  2  1 = write, 0 = read, per master
- i_m_req_addr  in  2*ADDR_W  packed addresses; master n occupies slice n
- i_m_req_wdata  in  2*DATA_W  packed write data
- i_m_req_wmask  in  2*DATA_W/8  packed byte strobes
- o_m_rsp_valid  out  2  response valid, per master
- i_m_rsp_ready  in  2  master ready to take the response
- o_m_rsp_rdata  out  DATA_W  shared read data, qualified by o_m_rsp_valid
- o_m_rsp_err  out  1  shared error flag, qualified by o_m_rsp_valid
- o_s_req_valid / i_s_req_ready  out/in  1  slave request handshake
- o_s_req_wen, o_s_req_addr, o_s_req_wdata, o_s_req_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- i_s_rsp_valid / o_s_rsp_ready  in/out  1  slave response handshake
- i_s_rsp_rdata, i_s_rsp_err  in  DATA_W/1  slave response fields

## Operation
- **Handshake rule.** A transfer on any valid/ready pair happens in a cycle where both are high. A source holds valid and its payload stable until the transfer.
- **FSM states.** IDLE, REQ, RSP.
- **IDLE.**
  - If any i_m_req_valid bit is high, pick a winner:
    - One requester: it wins.
    - Both requesting: the master not recorded in last_grant wins (round-robin).
  - Assert o_m_req_ready only for the winner, combinationally in the same cycle.
  - On the handshake: latch wen/addr/wdata/wmask and the grant index; set last_grant to the winner; go to REQ.
- **REQ.**
  - o_s_req_valid = 1, driven from the latched fields.
  - On i_s_req_ready go to RSP.
  - No further master request is accepted: o_m_req_ready = 0.
- **RSP.**
  - o_s_rsp_ready = i_m_rsp_ready[grant].
  - o_m_rsp_valid[grant] = i_s_rsp_valid; the other bit stays 0.
  - rdata and err pass through combinationally.
  - On the response handshake go to IDLE.
- **Unsolicited response.** If i_s_rsp_valid is high outside RSP, o_s_rsp_ready stays 0 and the response is ignored.
- **Write responses** carry no data. The slave still returns one response per request; rdata is don't-care and the master must ignore it.
- **Bus ordering.** Exactly one outstanding transaction; no pipelining across masters.

## Timing
- **Reset values:**
  - state = IDLE
  - last_grant = LSU, so the IFU wins the first tie
  - all o_*_valid and o_*_ready outputs = 0
  - o_s_req_wen/addr/wdata/wmask = 0
  - o_m_rsp_rdata = 0 and o_m_rsp_err = 0 (forced while not in RSP)
- **Minimum latency.** Master handshake at cycle 0, o_s_req_valid high at cycle 1. With a zero-wait slave, the response reaches the master at cycle 2 at the earliest.
- **Back-to-back.** A new grant is possible in the cycle after the RSP handshake, never in the same cycle.
- **Reset mid-operation.** Reset asserted in REQ or RSP aborts the transaction immediately and returns to IDLE. No response is delivered; the slave must also be reset.
- **Simultaneous arrival.** A request arriving in the same cycle as another master's RSP handshake waits; it is arbitrated in the next IDLE cycle.
- **Master behaviour during a transaction.** o_m_req_ready is never high outside IDLE. A master dropping i_m_rsp_ready stalls RSP indefinitely; there is no timeout.

## Structure
- **Package ysyx_24110006_bus_pkg:**
  - state enum {IDLE, REQ, RSP}
  - master index constants IFU = 0, LSU = 1
  - default ADDR_W / DATA_W constants
- **Sub-module ysyx_24110006_rr_arb.** Two-input round-robin grant logic: inputs are the request vector and last_grant, output is a one-hot grant. It is combinational and is instantiated once.
- **Flops:** state, grant index, last_grant and the latched request fields all live in this module.

## Test plan
- **Single read.** IFU read, addr 0x80000000; slave ready immediately and returns 0x00100073 one cycle later. Required: o_s_req_valid at cycle 1; o_m_rsp_valid = 2'b01 with rdata 0x00100073 at cycle 2; o_m_rsp_valid = 2'b00 for the LSU throughout.
- **Tie from reset.** Both masters request in the first cycle after reset. Required: IFU granted first; LSU granted in the IDLE cycle after the IFU response; grant order alternates IFU, LSU, IFU across 3 further ties.
- **Write payload and stalls.** LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011; slave holds i_s_req_ready low for 3 cycles. Required: o_s_req_wen/addr/wdata/wmask stable over all 4 REQ cycles; no o_m_req_ready during the stall.
- **Error response and master backpressure.** Slave returns err = 1 while the LSU holds i_m_rsp_ready = 0 for 2 cycles. Required: o_s_rsp_ready low for those 2 cycles; o_m_rsp_err = 1 delivered to the LSU on the handshake; FSM back in IDLE next cycle.
- **Reset while in RSP.** Assert i_reset low asynchronously mid-cycle while in RSP. Required: all outputs 0 before the next clock edge; after release, a tie grants the IFU.
- **Unsolicited slave response.** i_s_rsp_valid pulses while in IDLE. Required: o_s_rsp_ready = 0 and o_m_rsp_valid = 0.
